// File: rtl/core_alu_seq.sv
// core_alu_pkg: control word shared between core_alu and its sequencers.
// core_alu_seq: drives the 8-bit core_alu through a low-byte pass and a
// high-byte pass, with the carry chained between them, to do 16-bit
// ADD16/SUB16/INC16/DEC16 for address and pointer arithmetic.
// Ports:
//   I_clock, I_reset                 clock, synchronous active-high reset
//   I_req_valid/O_req_ready          request handshake (I_op, I_lhs, I_rhs)
//   O_rsp_valid/I_rsp_ready          response handshake
//   O_result/O_carry/O_zero/O_page_cross  response payload
//   O_alu_*                          core_alu inputs
//   I_alu_*                          core_alu outputs
package core_alu_pkg;
  typedef struct packed {
    logic [2:0] select;       // 3'd0 = pass lhs, 3'd2 = adc
    logic       set_carry;
    logic       result_zero;
    logic       clear_rhs;
    logic       invert_rhs;
    logic       clear_carry;
    logic       inv_i_carry;  // inverts the (possibly cleared) carry-in
  } control_type;

  localparam logic [2:0] ALU_SEL_ADC = 3'd2;
endpackage

module core_alu_seq
  import core_alu_pkg::*;
#(
  parameter bit FAST_NO_CROSS = 1'b1
) (
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_req_valid,
  output logic        O_req_ready,
  input  logic [1:0]  I_op,
  input  logic [15:0] I_lhs,
  input  logic [15:0] I_rhs,
  output logic        O_rsp_valid,
  input  logic        I_rsp_ready,
  output logic [15:0] O_result,
  output logic        O_carry,
  output logic        O_zero,
  output logic        O_page_cross,
  output control_type O_alu_control,
  output logic        O_alu_mask_p,
  output logic [7:0]  O_alu_lhs,
  output logic [7:0]  O_alu_rhs,
  output logic        O_alu_carry,
  input  logic [7:0]  I_alu_result,
  input  logic        I_alu_carry,
  input  logic        I_alu_zero
);

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_INC = 2'd2;
  localparam logic [1:0] OP_DEC = 2'd3;

  typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

  state_t      state, state_nxt;
  logic [1:0]  op_q;
  logic [15:0] lhs_q, rhs_q;
  logic [7:0]  lo_result;
  logic        lo_carry, lo_zero;
  logic [15:0] result_q;
  logic        carry_q, zero_q, cross_q;

  // Subtract-like ops add the inverted rhs, so a missing carry is a borrow.
  logic sub_like, cross_now, skip_hi;
  assign sub_like  = (op_q == OP_SUB) || (op_q == OP_DEC);
  assign cross_now = sub_like ? ~I_alu_carry : I_alu_carry;
  // INC/DEC with no page cross leave the high byte untouched.
  assign skip_hi   = FAST_NO_CROSS && op_q[1] && !cross_now;

  assign O_req_ready  = (state == IDLE) && !I_reset;
  assign O_rsp_valid  = (state == RESP);
  assign O_result     = result_q;
  assign O_carry      = carry_q;
  assign O_zero       = zero_q;
  assign O_page_cross = cross_q;

  always_ff @(posedge I_clock) begin
    if (I_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (I_req_valid) state_nxt = LO;
      LO:   state_nxt = skip_hi ? RESP : HI;
      HI:   state_nxt = RESP;
      RESP: if (I_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    O_alu_control = '0;
    O_alu_mask_p  = 1'b0;
    O_alu_lhs     = 8'h00;
    O_alu_rhs     = 8'h00;
    O_alu_carry   = 1'b0;
    if (state == LO || state == HI) begin
      O_alu_control.select      = ALU_SEL_ADC;
      O_alu_control.set_carry   = 1'b1;
      O_alu_control.result_zero = 1'b1;
      O_alu_control.clear_rhs   = op_q[1];
      O_alu_control.invert_rhs  = sub_like;
      O_alu_mask_p              = 1'b1;
      if (state == LO) begin
        O_alu_control.clear_carry = 1'b1;
        O_alu_control.inv_i_carry = (op_q == OP_SUB) || (op_q == OP_INC);
        O_alu_lhs                 = lhs_q[7:0];
        O_alu_rhs                 = rhs_q[7:0];
      end else begin
        O_alu_lhs   = lhs_q[15:8];
        O_alu_rhs   = rhs_q[15:8];
        O_alu_carry = lo_carry;
      end
    end
  end

  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      op_q      <= OP_ADD;
      lhs_q     <= '0;
      rhs_q     <= '0;
      lo_result <= '0;
      lo_carry  <= 1'b0;
      lo_zero   <= 1'b0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      cross_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (I_req_valid) begin
          op_q  <= I_op;
          lhs_q <= I_lhs;
          rhs_q <= I_rhs;
        end
        LO: begin
          lo_result <= I_alu_result;
          lo_carry  <= I_alu_carry;
          lo_zero   <= I_alu_zero;
          cross_q   <= cross_now;
          if (skip_hi) begin
            result_q <= {lhs_q[15:8], I_alu_result};
            carry_q  <= I_alu_carry;
            zero_q   <= I_alu_zero && (lhs_q[15:8] == 8'h00);
          end
        end
        HI: begin
          result_q <= {I_alu_result, lo_result};
          carry_q  <= I_alu_carry;
          zero_q   <= lo_zero && I_alu_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/core_alu_seq.md
Name: core_alu_seq

Overview:
- Multi-cycle sequencer that owns the 8-bit core_alu and drives it to perform 16-bit effective-address and pointer arithmetic: ADD16, SUB16, INC16 and DEC16.
- It splits each operation into a low-byte ALU pass and a high-byte ALU pass, chaining the carry between them.
- It reports the 16-bit result, the final carry, 16-bit zero and page-cross (low-byte carry or borrow).
- It sits between the core microsequencer (request/response handshake) and core_alu's input ports.

Parameters:
- FAST_NO_CROSS, 1, when 1, INC16/DEC16 with no page cross skip the high-byte ALU pass and copy lhs[15:8].

Ports:
- I_clock  in  1  core clock
- I_reset  in  1  synchronous, active-high reset
- I_req_valid  in  1  request valid
- O_req_ready  out  1  request accepted when valid&ready at a rising edge
- I_op  in  2  0=ADD16, 1=SUB16, 2=INC16, 3=DEC16
- I_lhs  in  16  left operand
- I_rhs  in  16  right operand, ignored for INC16/DEC16
- O_rsp_valid  out  1  response valid
- I_rsp_ready  in  1  response consumed when valid&ready
- O_result  out  16  result
- O_carry  out  1  final high-byte carry out
- O_zero  out  1  result==16'h0000
- O_page_cross  out  1  low-byte carry (ADD16/INC16) or low-byte borrow (SUB16/DEC16)
- O_alu_control  out  control_type  core_alu control word
- O_alu_mask_p  out  1  core_alu flag enable
- O_alu_lhs  out  8  core_alu lhs
- O_alu_rhs  out  8  core_alu rhs
- O_alu_carry  out  1  core_alu carry in
- I_alu_result  in  8  core_alu result
- I_alu_carry  in  1  core_alu carry out
- I_alu_zero  in  1  core_alu zero out

Behaviour:
- Clocking and reset: one clock, I_clock. I_reset is synchronous and active-high.
- Reset state: state IDLE. O_rsp_valid=0, O_result=0, O_carry=0, O_zero=0, O_page_cross=0.
- O_req_ready = (state==IDLE) && !I_reset.
- FSM transitions:
  - IDLE: on accept, latch op/lhs/rhs and go to LO.
  - LO: ALU computes the low byte; at the clock edge latch lo_result, lo_carry=I_alu_carry and lo_zero=I_alu_zero. Go to HI, or to RESP when FAST_NO_CROSS=1, op is INC16/DEC16 and there is no cross.
  - HI: ALU computes the high byte; at the edge latch the result and go to RESP.
  - RESP: O_rsp_valid=1; all response outputs are held stable until I_rsp_ready=1, then go to IDLE.
- Latency, accept edge to O_rsp_valid high: 3 cycles (accept edge plus LO and HI); 2 cycles when the high pass is skipped. There is no overlap: the next request can be accepted only in the cycle after the response handshake.
- ALU drive in LO/HI:
  - Select field = adc (3'd2).
  - Control bits set: control_set_carry and control_result_zero.
  - O_alu_mask_p=1.
  - O_alu_carry = 0 in LO; lo_carry in HI.
- Per-op LO controls:
  - ADD16: clear_carry.
  - SUB16: invert_rhs, clear_carry, inv_I_carry (carry-in 1).
  - INC16: clear_rhs, clear_carry, inv_I_carry.
  - DEC16: clear_rhs, invert_rhs, clear_carry (adds 0xFF).
- Per-op HI controls:
  - Same rhs controls as LO.
  - clear_carry and inv_I_carry are not set; the carry chains from lo_carry.
- Operand bytes: O_alu_lhs = lhs[7:0] in LO, lhs[15:8] in HI; O_alu_rhs likewise from rhs.
- Idle drive: in IDLE/RESP the ALU is driven with control all-zero (select =lhs), mask_p=0, and lhs/rhs/carry=0.
- Page cross = lo_carry for ADD16/INC16, and ~lo_carry for SUB16/DEC16.
- Response values:
  - Full path: O_carry = high-pass carry; O_zero = lo_zero & high-pass zero.
  - Skipped path: O_result={lhs[15:8],lo_result}; O_carry=lo_carry; O_zero=lo_zero & (lhs[15:8]==0).
- I_req_valid outside IDLE is ignored; the requester holds it.
- Reset asserted in any state: state goes to IDLE at that edge, the in-flight operation is dropped with no response, and outputs return to reset values.
- All arithmetic is modulo 2^16. Overflow and sign are not reported.

Test Plan:
- ADD16 lhs=0x12F0, rhs=0x0020 -> result 0x1310, carry 0, page_cross 1, zero 0; rsp_valid 3 cycles after accept.
- SUB16 lhs=0x1000, rhs=0x0001 -> result 0x0FFF, carry 1, page_cross 1 (low-byte borrow); ALU sees control invert_rhs with carry-in 1 in LO.
- INC16 lhs=0xFFFF -> result 0x0000, carry 1, zero 1, page_cross 1; both passes run for either FAST_NO_CROSS value.
- DEC16 lhs=0x2345:
  - With FAST_NO_CROSS=1 -> result 0x2344, carry 1, page_cross 0, rsp_valid 2 cycles after accept, HI state never entered.
  - With FAST_NO_CROSS=0 -> same values after 3 cycles.
- Backpressure: hold I_rsp_ready=0 for 4 cycles after rsp_valid while a second request is held valid -> response outputs stable, O_req_ready=0. The second request is accepted in the cycle after the handshake.
- Reset pulsed during HI -> next cycle O_rsp_valid=0, O_req_ready=1, outputs zero, no response ever issued for the dropped request.
